// File: rtl/unary_pkg.sv
// Shared helpers and result layout for the thermometer decode path.
package unary_pkg;

    localparam int W_ACC_DEF = 16;

    function automatic int w_unary(input int w_data);
        return 2 ** (w_data - 1);
    endfunction

    // Default-width result layout; parameterised modules build their own of width W_ACC.
    typedef struct packed {
        logic                 err;
        logic                 ovf;
        logic [W_ACC_DEF-1:0] sum;
    } unary_res_t;

endpackage

// File: rtl/thermo2bin.sv
// Combinational thermometer decoder: counts the run of 1s from bit 0 and
// flags any 1 found above the first 0.
module thermo2bin
    import unary_pkg::*;
#(
    parameter int W_DATA = 6,
    localparam int W_UNARY = w_unary(W_DATA)
) (
    input  logic [W_UNARY-1:0] thermo,
    output logic [W_DATA-1:0]  cnt,
    output logic               bad
);

    logic run;

    always_comb begin
        cnt = '0;
        bad = 1'b0;
        run = 1'b1;
        for (int unsigned i = 0; i < W_UNARY; i++) begin
            if (thermo[i]) begin
                if (run) cnt = cnt + 1'b1;
                else     bad = 1'b1;
            end else begin
                run = 1'b0;
            end
        end
    end

endmodule

// File: rtl/unary_decode.sv
// Accumulates thermometer beat counts per eot-delimited transaction and emits
// {err, ovf, sum}. Define UNARY_DECODE_SATURATE_EN to clamp the sum instead of wrapping.
module unary_decode
    import unary_pkg::*;
#(
    parameter int W_DATA = 6,
    parameter int W_ACC  = 16,
    localparam int W_UNARY = w_unary(W_DATA)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               din_valid,
    output logic               din_ready,
    input  logic [W_UNARY:0]   din_data,
    output logic               dout_valid,
    input  logic               dout_ready,
    output logic [W_ACC+1:0]   dout_data
);

    typedef struct packed {
        logic             err;
        logic             ovf;
        logic [W_ACC-1:0] sum;
    } res_t;

    logic [W_DATA-1:0] cnt;
    logic              bad;
    logic              eot;
    logic              accept;
    logic [W_ACC-1:0]  acc;
    logic              err_acc;
    logic              ovf_acc;
    logic [W_ACC:0]    sum_ext;
    logic              carry;
    logic [W_ACC-1:0]  sum_next;
    res_t              result;

    thermo2bin #(.W_DATA(W_DATA)) u_thermo2bin (
        .thermo (din_data[W_UNARY-1:0]),
        .cnt    (cnt),
        .bad    (bad)
    );

    assign eot       = din_data[W_UNARY];
    assign din_ready = !dout_valid || dout_ready;
    assign accept    = din_valid && din_ready;

    always_comb begin
        sum_ext = {1'b0, acc} + {{(W_ACC + 1 - W_DATA){1'b0}}, cnt};
        carry   = sum_ext[W_ACC];
`ifdef UNARY_DECODE_SATURATE_EN
        sum_next = carry ? '1 : sum_ext[W_ACC-1:0];
`else
        sum_next = sum_ext[W_ACC-1:0];
`endif
        result.err = err_acc | bad;
        result.ovf = ovf_acc | carry;
        result.sum = sum_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc        <= '0;
            err_acc    <= 1'b0;
            ovf_acc    <= 1'b0;
            dout_valid <= 1'b0;
            dout_data  <= '0;
        end else begin
            if (accept && eot) begin
                // A new result may replace one being consumed this cycle: no bubble.
                dout_data  <= result;
                dout_valid <= 1'b1;
                acc        <= '0;
                err_acc    <= 1'b0;
                ovf_acc    <= 1'b0;
            end else begin
                if (accept) begin
                    acc     <= sum_next;
                    err_acc <= result.err;
                    ovf_acc <= result.ovf;
                end
                if (dout_valid && dout_ready) dout_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_unary_decode.sv
// Directed self-checking bench for unary_decode (W_DATA=6) with a second W_ACC=6 instance
// for overflow; expectations follow UNARY_DECODE_SATURATE_EN.
module tb_unary_decode;

    logic        clk = 1'b0;
    logic        rst;
    logic        din_valid;
    logic        din_ready;
    logic [32:0] din_data;
    logic        dout_valid;
    logic        dout_ready;
    logic [17:0] dout_data;

    logic        din2_valid;
    logic        din2_ready;
    logic [32:0] din2_data;
    logic        dout2_valid;
    logic        dout2_ready;
    logic [7:0]  dout2_data;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    unary_decode #(.W_DATA(6), .W_ACC(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .din_data   (din_data),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_data  (dout_data)
    );

    unary_decode #(.W_DATA(6), .W_ACC(6)) dut_small (
        .clk        (clk),
        .rst        (rst),
        .din_valid  (din2_valid),
        .din_ready  (din2_ready),
        .din_data   (din2_data),
        .dout_valid (dout2_valid),
        .dout_ready (dout2_ready),
        .dout_data  (dout2_data)
    );

    // Presents one beat and returns 1 ns after the edge that transferred it.
    task automatic send_beat(input logic eot, input logic [31:0] th);
        din_valid = 1'b1;
        din_data  = {eot, th};
        for (int i = 0; i < 50; i++) begin
            if (din_ready) begin
                @(posedge clk); #1;
                din_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        tests++; fails++;
        $display("FAIL send_timeout: din_ready stayed %0b, required 1", din_ready);
        din_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; din_valid = 1'b0; din_data = '0; dout_ready = 1'b1;
        din2_valid = 1'b0; din2_data = '0; dout2_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (dout_valid !== 1'b0 || dout_data !== 18'h0) begin
            fails++;
            $display("FAIL reset_state: valid=%0b data=%h, required valid=0 data=0", dout_valid, dout_data);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_single_beat;
        send_beat(1'b1, 32'h0000_00FF);
        tests++;
        if (dout_valid !== 1'b1 || dout_data !== {2'b00, 16'd8}) begin
            fails++;
            $display("FAIL single_beat: valid=%0b data=%h, required valid=1 data=%h", dout_valid, dout_data, {2'b00, 16'd8});
        end
        @(posedge clk); #1;
        tests++;
        if (dout_valid !== 1'b0) begin
            fails++;
            $display("FAIL single_beat_drain: valid=%0b, required 0", dout_valid);
        end
        send_beat(1'b1, 32'h0);
        tests++;
        if (dout_valid !== 1'b1 || dout_data !== 18'h0) begin
            fails++;
            $display("FAIL all_zero_beat: data=%h, required 0", dout_data);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_multi_beat;
        send_beat(1'b0, 32'h7);
        tests++;
        if (dout_valid !== 1'b0) begin
            fails++;
            $display("FAIL multi_no_early_out: valid=%0b, required 0", dout_valid);
        end
        send_beat(1'b0, 32'h0);
        send_beat(1'b1, 32'hFFFF_FFFF);
        tests++;
        if (dout_valid !== 1'b1 || dout_data !== {2'b00, 16'd35}) begin
            fails++;
            $display("FAIL multi_beat_sum: valid=%0b data=%h, required valid=1 data=%h", dout_valid, dout_data, {2'b00, 16'd35});
        end
        @(posedge clk); #1;
        send_beat(1'b1, 32'h1);
        tests++;
        if (dout_valid !== 1'b1 || dout_data !== {2'b00, 16'd1}) begin
            fails++;
            $display("FAIL multi_next_txn: data=%h, required %h", dout_data, {2'b00, 16'd1});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_err_sticky;
        send_beat(1'b0, 32'h5);
        send_beat(1'b1, 32'h3);
        tests++;
        if (dout_valid !== 1'b1 || dout_data !== {2'b10, 16'd3}) begin
            fails++;
            $display("FAIL err_flag: data=%h, required %h", dout_data, {2'b10, 16'd3});
        end
        @(posedge clk); #1;
        send_beat(1'b1, 32'h3);
        tests++;
        if (dout_data !== {2'b00, 16'd2}) begin
            fails++;
            $display("FAIL err_cleared: data=%h, required %h", dout_data, {2'b00, 16'd2});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure;
        dout_ready = 1'b0;
        send_beat(1'b1, 32'h1);
        din_valid = 1'b1;
        din_data  = {1'b1, 32'h3};
        for (int i = 0; i < 5; i++) begin
            tests++;
            if (din_ready !== 1'b0 || dout_valid !== 1'b1 || dout_data !== {2'b00, 16'd1}) begin
                fails++;
                $display("FAIL hold_cycle%0d: din_ready=%0b valid=%0b data=%h, required 0 1 %h",
                         i, din_ready, dout_valid, dout_data, {2'b00, 16'd1});
            end
            @(posedge clk); #1;
        end
        dout_ready = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (dout_valid !== 1'b1 || dout_data !== {2'b00, 16'd2}) begin
            fails++;
            $display("FAIL b2b_first: valid=%0b data=%h, required 1 %h", dout_valid, dout_data, {2'b00, 16'd2});
        end
        din_data = {1'b1, 32'h7};
        @(posedge clk); #1;
        tests++;
        if (dout_valid !== 1'b1 || dout_data !== {2'b00, 16'd3}) begin
            fails++;
            $display("FAIL b2b_second: valid=%0b data=%h, required 1 %h", dout_valid, dout_data, {2'b00, 16'd3});
        end
        din_data = {1'b1, 32'hF};
        @(posedge clk); #1;
        din_valid = 1'b0;
        tests++;
        if (dout_valid !== 1'b1 || dout_data !== {2'b00, 16'd4}) begin
            fails++;
            $display("FAIL b2b_third: valid=%0b data=%h, required 1 %h", dout_valid, dout_data, {2'b00, 16'd4});
        end
        @(posedge clk); #1;
        tests++;
        if (dout_valid !== 1'b0) begin
            fails++;
            $display("FAIL b2b_drain: valid=%0b, required 0", dout_valid);
        end
    endtask

    task automatic test_overflow;
        logic [7:0] exp;
`ifdef UNARY_DECODE_SATURATE_EN
        exp = {2'b01, 6'd63};
`else
        exp = {2'b01, 6'd32};
`endif
        din2_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            din2_data = {(i == 2), 32'hFFFF_FFFF};
            tests++;
            if (din2_ready !== 1'b1) begin
                fails++;
                $display("FAIL ovf_ready%0d: din_ready=%0b, required 1", i, din2_ready);
            end
            @(posedge clk); #1;
        end
        din2_valid = 1'b0;
        tests++;
        if (dout2_valid !== 1'b1 || dout2_data !== exp) begin
            fails++;
            $display("FAIL overflow_sum: valid=%0b data=%h, required 1 %h", dout2_valid, dout2_data, exp);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_txn;
        send_beat(1'b0, 32'hF);
        send_beat(1'b0, 32'hF);
        rst = 1'b1;
        #1;
        tests++;
        if (dout_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_during: valid=%0b, required 0", dout_valid);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        tests++;
        if (dout_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_after: valid=%0b, required 0", dout_valid);
        end
        send_beat(1'b1, 32'h1);
        tests++;
        if (dout_valid !== 1'b1 || dout_data !== {2'b00, 16'd1}) begin
            fails++;
            $display("FAIL reset_new_txn: data=%h, required %h", dout_data, {2'b00, 16'd1});
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset;
        test_single_beat;
        test_multi_beat;
        test_err_sticky;
        test_backpressure;
        test_overflow;
        test_reset_mid_txn;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
